uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter: the next generation of the fixed-format transmitter in `transmitter_top`. It buffers bytes in an internal FIFO and serialises them onto a single TX line. Data width, parity mode, stop-bit count, baud divisor and FIFO depth are all configurable. It sits between the pushbutton/host write logic and the `txdata` pin of the top level.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 104: hwclk cycles per serial bit; must be ≥ 2.
- `DATA_BITS`, default 8: payload width; legal range 5–9.
- `PARITY`, default `PAR_NONE`: one of `PAR_NONE`, `PAR_ODD`, `PAR_EVEN` (`parity_t` from the package).
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: number of entries; must be a power of 2, ≥ 2.

Ports:
- `hwclk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe; enqueues `wr_data` this cycle if not `full`.
- `wr_data`  in  DATA_BITS  payload to enqueue.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `overflow`  out  1  sticky flag; set by a write attempted while `full`.
- `busy`  out  1  high while a frame is on the line (any state other than IDLE).
- `txd`  out  1  serial output, idle high.

## Operation

- Reset values: `txd`=1, `busy`=0, `empty`=1, `full`=0, `overflow`=0. FIFO pointers are cleared and the FSM goes to IDLE.
- Reset asserted mid-frame aborts the frame immediately; `txd` returns to 1 asynchronously.
- FIFO behaviour:
  - A write when not `full` is stored at the write pointer.
  - A write when `full` is dropped, the FIFO is unchanged, and `overflow` goes to 1 until reset.
  - A simultaneous pop and write on a full FIFO is still dropped: the `full` check uses the pre-edge state.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. `full` and `empty` come from an MSB compare.
- FSM states are IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: `txd`=1. If `!empty`, pop the FIFO head into the shift register, clear the bit counter, and go to START.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: `txd` = shift register LSB, sent LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After DATA_BITS bits, go to PARITY if `PARITY != PAR_NONE`, otherwise STOP.
  - PARITY: `txd` = XOR of the payload for EVEN, or its inverse for ODD. The value is computed at pop time and held. Lasts one bit time.
  - STOP: `txd`=1 for STOP_BITS × CLKS_PER_BIT cycles, then IDLE.
- Back-to-back frames: on the STOP→IDLE edge, if the FIFO is non-empty, IDLE pops on the next edge. This gives exactly one idle cycle between frames.
- Baud counter: counts 0..CLKS_PER_BIT-1 and is cleared on every state change.

## Timing

- Latency: `wr_en` sampled at edge N into an empty, idle block. `empty` falls after N. The pop and START happen at edge N+1, so `txd`=0 from N+1.
- Frame length is (1 + DATA_BITS + (PARITY≠NONE) + STOP_BITS) × CLKS_PER_BIT cycles, plus 1 idle cycle.
- `full`, `empty` and `busy` are registered-state decodes, valid the cycle after the causing edge.

## Structure

- Package `uart_pkg` holds:
  - `typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t`
  - `tx_state_t` (IDLE, START, DATA, PARITY, STOP)
  - the `clog2`-based counter-width constant helpers.
- Sub-module `uart_tx_fifo` (params DATA_BITS, FIFO_DEPTH; ports `hwclk`, `reset`, `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`). `uart_tx_param` wraps it together with the FSM and `overflow`.

## Test plan

All scenarios use CLKS_PER_BIT=4.

- DATA_BITS=8, PAR_NONE, 1 stop; write 0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); `busy` high throughout.
- Same byte with PAR_EVEN → parity bit 0 before stop. With PAR_ODD → parity bit 1. Frame is 44 cycles.
- STOP_BITS=2, DATA_BITS=5; write 0x13 → 0,1,1,0,0,1, then 1 for 8 cycles.
- FIFO_DEPTH=4; write 0x01..0x06 on consecutive cycles → 0x01 pops immediately, 0x02..0x05 are queued, and 0x06 is dropped. `full`=1 and `overflow`=1. Output frames are 0x01..0x05, each separated by exactly 1 idle cycle, then `empty`=1 and `busy`=0.
- Assert `reset` during the DATA state of frame 0xFF → `txd`=1 with no clock edge. After release, `empty`=1, `busy`=0 and `overflow`=0, and the line stays high with no residual frame.

Source files
------------

// File: rtl/uart_tx_param_pkg.sv
// Shared types and width helpers for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;

    // State names carry an ST_ prefix so they cannot collide with the PARITY parameter.
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_t;

    // Bits needed for a counter that runs 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side write/status bundle of the UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 full;
    logic                 empty;
    logic                 overflow;
    logic                 busy;
    logic                 txd;

    modport master (
        output wr_en, wr_data,
        input  full, empty, overflow, busy, txd
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, overflow, busy, txd
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: extra pointer MSB distinguishes full from empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 hwclk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = cnt_w(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic                 do_wr;
    logic                 do_rd;

    // full/empty are evaluated on the pre-edge pointers, so a write into a full FIFO is dropped even when a pop happens on the same edge
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_data = mem[rptr[AW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    // Storage array, no reset needed on payload
    always_ff @(posedge hwclk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered, configurable frame format.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 104,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      FIFO_DEPTH   = 4
) (
    input  logic         hwclk,
    input  logic         reset,
    uart_tx_param_if.slave bus
);
    localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
    localparam int BIT_W  = cnt_w(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            nxt;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 bit_end;
    logic                 rd_en;
    logic [DATA_BITS-1:0] rd_data;
    logic                 full;
    logic                 empty;
    logic                 overflow;

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~(^d) : ^d;
    endfunction

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .hwclk  (hwclk),
        .reset  (reset),
        .wr_en  (bus.wr_en),
        .wr_data(bus.wr_data),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .full   (full),
        .empty  (empty)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign rd_en   = (state == ST_IDLE) && !empty;

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow;

    // Sticky overflow: any write attempt against a full FIFO
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset)                   overflow <= 1'b0;
        else if (bus.wr_en && full)  overflow <= 1'b1;
    end

    // State register plus baud/bit counters, both cleared on every state change
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (bit_end) begin
                baud_cnt <= '0;
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Shift register and parity bit: loaded at pop, shifted at the end of each data bit
    always_ff @(posedge hwclk) begin
        if (rd_en) begin
            shreg   <= rd_data;
            par_bit <= par_of(rd_data);
        end else if (state == ST_DATA && bit_end) begin
            shreg <= shreg >> 1;
        end
    end

    // Next-state decode
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:   if (!empty) nxt = ST_START;
            ST_START:  if (bit_end) nxt = ST_DATA;
            ST_DATA:   if (bit_end && bit_cnt == DATA_LAST)
                           nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) nxt = ST_STOP;
            ST_STOP:   if (bit_end && bit_cnt == STOP_LAST) nxt = ST_IDLE;
            default:   nxt = ST_IDLE;
        endcase
    end

    // Line driver: decoded from state so reset forces the line high without a clock
    always_comb begin
        bus.txd  = 1'b1;
        bus.busy = (state != ST_IDLE);
        case (state)
            ST_START:  bus.txd = 1'b0;
            ST_DATA:   bus.txd = shreg[0];
            ST_PARITY: bus.txd = par_bit;
            default:   bus.txd = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four frame formats, FIFO overflow, async reset.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic hwclk = 1'b0;
    logic rst;
    always #5 hwclk = ~hwclk;

    int checks   = 0;
    int failures = 0;

    logic [3:0] wr_en_v;
    logic [8:0] wr_data_v [4];
    logic [3:0] txd_all, busy_all, empty_all, full_all, ovf_all;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(5)) if3 ();

    assign if0.wr_en = wr_en_v[0];  assign if0.wr_data = wr_data_v[0][7:0];
    assign if1.wr_en = wr_en_v[1];  assign if1.wr_data = wr_data_v[1][7:0];
    assign if2.wr_en = wr_en_v[2];  assign if2.wr_data = wr_data_v[2][7:0];
    assign if3.wr_en = wr_en_v[3];  assign if3.wr_data = wr_data_v[3][4:0];

    assign txd_all   = {if3.txd, if2.txd, if1.txd, if0.txd};
    assign busy_all  = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign empty_all = {if3.empty, if2.empty, if1.empty, if0.empty};
    assign full_all  = {if3.full, if2.full, if1.full, if0.full};
    assign ovf_all   = {if3.overflow, if2.overflow, if1.overflow, if0.overflow};

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut0 (.hwclk(hwclk), .reset(rst), .bus(if0));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut1 (.hwclk(hwclk), .reset(rst), .bus(if1));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        dut2 (.hwclk(hwclk), .reset(rst), .bus(if2));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        dut3 (.hwclk(hwclk), .reset(rst), .bus(if3));

    // Scoreboard queues and FIFO occupancy model, one per instance
    logic [8:0] sb0[$], sb1[$], sb2[$], sb3[$];
    int m_cnt  [4];
    bit m_idle [4];
    bit m_ovf  [4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sb_push(input int k, input logic [8:0] d);
        case (k)
            0: sb0.push_back(d);
            1: sb1.push_back(d);
            2: sb2.push_back(d);
            default: sb3.push_back(d);
        endcase
    endtask

    task automatic sb_pop(input int k, output logic [8:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        case (k)
            0: if (sb0.size() > 0) begin d = sb0.pop_front(); ok = 1'b1; end
            1: if (sb1.size() > 0) begin d = sb1.pop_front(); ok = 1'b1; end
            2: if (sb2.size() > 0) begin d = sb2.pop_front(); ok = 1'b1; end
            default: if (sb3.size() > 0) begin d = sb3.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_idle[i] = 1'b1;
            m_ovf[i]  = 1'b0;
        end
        sb0.delete(); sb1.delete(); sb2.delete(); sb3.delete();
    endtask

    task automatic do_reset();
        @(negedge hwclk);
        rst = 1'b1;
        model_clear();
        @(negedge hwclk);
        rst = 1'b0;
    endtask

    // One write cycle; model decides accept/drop from pre-edge occupancy
    task automatic wr(input int k, input logic [8:0] d);
        bit pop;
        wr_en_v[k]   = 1'b1;
        wr_data_v[k] = d;
        @(posedge hwclk);
        pop = m_idle[k] && (m_cnt[k] > 0);
        if (m_cnt[k] < DEPTH) begin
            sb_push(k, d);
            m_cnt[k]++;
        end else begin
            m_ovf[k] = 1'b1;
        end
        if (pop) begin
            m_cnt[k]--;
            m_idle[k] = 1'b0;
        end
        @(negedge hwclk);
        wr_en_v[k] = 1'b0;
    endtask

    task automatic wait_start(input int k, output int waited);
        waited = 0;
        while (txd_all[k] !== 1'b0 && waited < 200) begin
            @(negedge hwclk);
            waited++;
        end
        chk($sformatf("start_seen_%0d", k), 32'(txd_all[k]), 32'd0);
    endtask

    // Called on the first negedge of a frame; ends on the idle cycle after it
    task automatic check_frame(input int k, input int nb, input int par, input int stops);
        logic [8:0] d;
        bit         ok;
        logic       p, e;
        logic [8:0] cap;
        logic       pcap;
        int         nbits, terr, berr, bi;
        sb_pop(k, d, ok);
        chk($sformatf("sb_nonempty_%0d", k), 32'(ok), 32'd1);
        p = 1'b0;
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        if (par == 1) p = ~p;
        nbits = 1 + nb + ((par != 0) ? 1 : 0) + stops;
        terr = 0; berr = 0; cap = '0; pcap = 1'b0;
        for (int c = 0; c < nbits * CPB; c++) begin
            if (c > 0) @(negedge hwclk);
            bi = c / CPB;
            if (bi == 0)                      e = 1'b0;
            else if (bi <= nb)                e = d[bi-1];
            else if (par != 0 && bi == nb+1)  e = p;
            else                              e = 1'b1;
            if (txd_all[k] !== e)     terr++;
            if (busy_all[k] !== 1'b1) berr++;
            if (c % CPB == CPB / 2) begin
                if (bi >= 1 && bi <= nb)          cap[bi-1] = txd_all[k];
                if (par != 0 && bi == nb + 1)     pcap = txd_all[k];
            end
        end
        chk($sformatf("frame_txd_err_%0d", k), 32'(terr), 32'd0);
        chk($sformatf("frame_busy_err_%0d", k), 32'(berr), 32'd0);
        chk($sformatf("payload_%0d", k), 32'(cap), 32'(d));
        if (par != 0) chk($sformatf("parity_%0d", k), 32'(pcap), 32'(p));
        @(negedge hwclk);
        chk($sformatf("idle_busy_%0d", k), 32'(busy_all[k]), 32'd0);
        chk($sformatf("idle_txd_%0d", k), 32'(txd_all[k]), 32'd1);
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w, lows;
        rst = 1'b1;
        wr_en_v = '0;
        for (int i = 0; i < 4; i++) wr_data_v[i] = '0;
        model_clear();

        // Reset state
        @(negedge hwclk);
        chk("rst_txd", 32'(txd_all[0]), 32'd1);
        chk("rst_busy", 32'(busy_all[0]), 32'd0);
        chk("rst_empty", 32'(empty_all[0]), 32'd1);
        chk("rst_full", 32'(full_all[0]), 32'd0);
        chk("rst_overflow", 32'(ovf_all[0]), 32'd0);

        // 8N1 frame with latency check
        do_reset();
        wr(0, 9'h0A5);
        chk("lat_empty_n", 32'(empty_all[0]), 32'd0);
        chk("lat_txd_n", 32'(txd_all[0]), 32'd1);
        chk("lat_busy_n", 32'(busy_all[0]), 32'd0);
        @(negedge hwclk);
        chk("lat_txd_n1", 32'(txd_all[0]), 32'd0);
        chk("lat_busy_n1", 32'(busy_all[0]), 32'd1);
        chk("lat_empty_n1", 32'(empty_all[0]), 32'd1);
        wait_start(0, w);
        check_frame(0, 8, 0, 1);

        // Even and odd parity
        do_reset();
        wr(1, 9'h0A5);
        wait_start(1, w);
        check_frame(1, 8, 2, 1);
        do_reset();
        wr(2, 9'h0A5);
        wait_start(2, w);
        check_frame(2, 8, 1, 1);

        // 5 data bits, 2 stop bits
        do_reset();
        wr(3, 9'h013);
        wait_start(3, w);
        check_frame(3, 5, 0, 2);

        // FIFO fill, overflow, back-to-back frames
        do_reset();
        fork
            begin
                for (int i = 1; i <= 6; i++) wr(0, 9'(i));
                chk("fifo_full", 32'(full_all[0]), 32'd1);
                chk("fifo_overflow", 32'(ovf_all[0]), 32'(m_ovf[0]));
            end
            begin
                for (int f = 0; f < 5; f++) begin
                    if (f > 0) @(negedge hwclk);
                    wait_start(0, w);
                    if (f > 0) chk($sformatf("b2b_gap_%0d", f), 32'(w), 32'd0);
                    check_frame(0, 8, 0, 1);
                end
            end
        join
        chk("drain_empty", 32'(empty_all[0]), 32'd1);
        chk("drain_busy", 32'(busy_all[0]), 32'd0);
        chk("drain_sb_left", 32'(sb0.size()), 32'd0);

        // Reset in the middle of a data bit
        wr(0, 9'h0FF);
        repeat (8) @(negedge hwclk);
        chk("mid_busy", 32'(busy_all[0]), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_txd", 32'(txd_all[0]), 32'd1);
        chk("async_busy", 32'(busy_all[0]), 32'd0);
        @(negedge hwclk);
        rst = 1'b0;
        model_clear();
        chk("post_empty", 32'(empty_all[0]), 32'd1);
        chk("post_busy", 32'(busy_all[0]), 32'd0);
        chk("post_overflow", 32'(ovf_all[0]), 32'd0);
        chk("post_full", 32'(full_all[0]), 32'd0);
        lows = 0;
        repeat (60) begin
            @(negedge hwclk);
            if (txd_all[0] !== 1'b1 || busy_all[0] !== 1'b0) lows++;
        end
        chk("no_residual", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
